mips_debug_reader: RTL

Host-side controller for the `mips` core's debug port: it drives `debug_en`, `debug_step` and `debug_addr`, and reads `debug_data`. It halts the core, single-steps it, or sweeps a range of debug addresses (register file / CP0 view). Each captured word is streamed out over a valid/ready interface to a downstream consumer (UART formatter, VGA overlay, bench monitor). It sits beside `mips` at the top level and replaces hand-driven debug inputs.

---
 rtl/mips_debug_pkg.sv | 6 +
 rtl/mips_debug_reader.sv | 110 +++++++++++
 2 files changed

// File: rtl/mips_debug_pkg.sv
// mips_debug_pkg: debug-port widths shared with mips and the reader FSM states.
package mips_debug_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {RUN, HALT, SCAN, HOLD, STEP} state_e;
endpackage

// File: rtl/mips_debug_reader.sv
// mips_debug_reader: halts, steps or sweeps the mips debug port and streams captured words out.
module mips_debug_reader #(
  parameter int ADDR_W     = mips_debug_pkg::ADDR_W,
  parameter int DATA_W     = mips_debug_pkg::DATA_W,
  parameter int RD_LAT     = 1,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_req,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              snap_req,
  output logic              debug_en,
  output logic              debug_step,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy
);
  import mips_debug_pkg::*;
  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
  localparam logic [3:0]        LAT_M1  = 4'(RD_LAT - 1);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                en_q, step_q, valid_q, busy_q;
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    unique case (state_q)
      RUN: begin
        if (snap_req) begin
          state_d = SCAN;
          addr_d  = FIRST_A;
          cnt_d   = LAT_M1;
        end else if (halt_req) state_d = HALT;
      end
      HALT: begin
        if (snap_req) begin
          state_d = SCAN;
          addr_d  = FIRST_A;
          cnt_d   = LAT_M1;
        end else if (step_req) state_d = STEP;
        else if (run_req) state_d = RUN;
      end
      STEP: state_d = HALT;
      SCAN: begin
        if (cnt_q == '0) begin
          out_data_d = debug_data;
          out_addr_d = addr_q;
          state_d    = HOLD;
        end else cnt_d = cnt_q - 4'd1;
      end
      HOLD: begin
        if (out_ready) begin
          if (addr_q == LAST_A) state_d = HALT;
          else begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = LAT_M1;
            state_d = SCAN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end
  // Flag outputs are decoded from the next state so they stay registered yet track state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      addr_q     <= FIRST_A;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_addr_q <= FIRST_A;
      en_q       <= 1'b0;
      step_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      en_q       <= state_d != RUN;
      step_q     <= state_d == STEP;
      valid_q    <= state_d == HOLD;
      busy_q     <= state_d inside {SCAN, HOLD, STEP};
    end
  end
  assign debug_en   = en_q;
  assign debug_step = step_q;
  assign debug_addr = addr_q;
  assign out_valid  = valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign out_last   = valid_q && (out_addr_q == LAST_A);
  assign busy       = busy_q;
endmodule
